alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 110 +++++++++++
 tb/tb_alu_writeback.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: single-entry ALU result writeback stage with 8x16 regfile, flag register and condition evaluator
// Optional feature: define ALU_WB_BYPASS_EN to forward the pending entry to rd_data and condition evaluation.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            result handshake; in_bus = {C,Z,V,S,data[15:0]}
//   in_dest, in_flag_we          destination register, flag-update enable
//   wb_en                        commit enable for the pending entry
//   rd_addr/rd_data              combinational read port
//   cond_valid/cond_ready        condition request handshake, cond_code selects the test
//   cond_done/cond_taken         one-cycle completion pulse and held result
//   flags                        architectural {C,Z,V,S}
module alu_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_bus,
    input  logic [2:0]  in_dest,
    input  logic        in_flag_we,
    input  logic        wb_en,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    input  logic        cond_valid,
    input  logic [3:0]  cond_code,
    output logic        cond_ready,
    output logic        cond_done,
    output logic        cond_taken,
    output logic [3:0]  flags
);
    logic        pend_valid;
    logic [15:0] pend_data;
    logic [2:0]  pend_dest;
    logic [3:0]  pend_flags;
    logic        pend_flag_we;
    logic [15:0] regs [8];
    logic [3:0]  flag_reg;
    logic [3:0]  cond_flags;
    logic        commit;
    logic        accept;
    logic        cond_fire;

    // f is {C,Z,V,S}
    function automatic logic eval(input logic [3:0] code, input logic [3:0] f);
        logic sv;
        sv = f[0] ^ f[1];
        case (code)
            4'd0:    eval = 1'b1;
            4'd1:    eval = f[2];
            4'd2:    eval = !f[2];
            4'd3:    eval = f[0];
            4'd4:    eval = !f[0];
            4'd5:    eval = f[1];
            4'd6:    eval = !f[1];
            4'd7:    eval = f[3];
            4'd8:    eval = !f[3];
            4'd9:    eval = sv;
            4'd10:   eval = !sv;
            4'd11:   eval = f[2] | sv;
            4'd12:   eval = !f[2] & !sv;
            default: eval = 1'b0;
        endcase
    endfunction

    assign flags     = flag_reg;
    assign in_ready  = !pend_valid | wb_en;
    assign commit    = pend_valid & wb_en;
    assign accept    = in_valid & in_ready;
    assign cond_fire = cond_valid & cond_ready;

`ifdef ALU_WB_BYPASS_EN
    assign cond_ready = 1'b1;
    assign cond_flags = (pend_valid & pend_flag_we) ? pend_flags : flag_reg;
    assign rd_data    = (pend_valid && pend_dest == rd_addr) ? pend_data : regs[rd_addr];
`else
    // Without forwarding, a condition must wait until pending flags are architectural.
    assign cond_ready = !(pend_valid & pend_flag_we);
    assign cond_flags = flag_reg;
    assign rd_data    = regs[rd_addr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid   <= 1'b0;
            pend_data    <= '0;
            pend_dest    <= '0;
            pend_flags   <= '0;
            pend_flag_we <= 1'b0;
            flag_reg     <= '0;
            cond_done    <= 1'b0;
            cond_taken   <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (commit) begin
                regs[pend_dest] <= pend_data;
                if (pend_flag_we) flag_reg <= pend_flags;
            end
            if (accept) begin
                pend_valid   <= 1'b1;
                pend_data    <= in_bus[15:0];
                pend_flags   <= in_bus[19:16];
                pend_dest    <= in_dest;
                pend_flag_we <= in_flag_we;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
            cond_done <= cond_fire;
            if (cond_fire) cond_taken <= eval(cond_code, cond_flags);
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed, table-driven self-checking bench for alu_writeback
module tb_alu_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_bus = '0;
    logic [2:0]  in_dest = '0;
    logic        in_flag_we = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        cond_valid = 1'b0;
    logic [3:0]  cond_code = '0;
    logic        cond_ready;
    logic        cond_done;
    logic        cond_taken;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] code;
        logic [3:0] f;
        logic       exp;
    } vec_t;

    vec_t vecs [18];

    alu_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bus(in_bus), .in_dest(in_dest), .in_flag_we(in_flag_we), .wb_en(wb_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .cond_valid(cond_valid),
        .cond_code(cond_code), .cond_ready(cond_ready), .cond_done(cond_done),
        .cond_taken(cond_taken), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [19:0] bus, input logic [2:0] dest, input logic fwe);
        in_valid = 1'b1;
        in_bus = bus;
        in_dest = dest;
        in_flag_we = fwe;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        wb_en = 1'b1;
        push({f, 16'h0}, 3'd0, 1'b1);
        tick();
        chk("set_flags", flags, f);
    endtask

    task automatic cond_req(input string name, input logic [3:0] code, input logic exp);
        cond_valid = 1'b1;
        cond_code = code;
        tick();
        cond_valid = 1'b0;
        chk({name, "_done"}, cond_done, 1'b1);
        chk({name, "_taken"}, cond_taken, exp);
        tick();
        chk({name, "_done_low"}, cond_done, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  4'b0000, 1'b1};
        vecs[1]  = '{4'd1,  4'b0100, 1'b1};
        vecs[2]  = '{4'd1,  4'b0000, 1'b0};
        vecs[3]  = '{4'd2,  4'b0100, 1'b0};
        vecs[4]  = '{4'd3,  4'b0001, 1'b1};
        vecs[5]  = '{4'd4,  4'b0001, 1'b0};
        vecs[6]  = '{4'd5,  4'b0010, 1'b1};
        vecs[7]  = '{4'd6,  4'b0010, 1'b0};
        vecs[8]  = '{4'd7,  4'b1000, 1'b1};
        vecs[9]  = '{4'd8,  4'b1000, 1'b0};
        vecs[10] = '{4'd9,  4'b0001, 1'b1};
        vecs[11] = '{4'd10, 4'b0011, 1'b1};
        vecs[12] = '{4'd11, 4'b0011, 1'b0};
        vecs[13] = '{4'd12, 4'b0000, 1'b1};
        vecs[14] = '{4'd12, 4'b0101, 1'b0};
        vecs[15] = '{4'd13, 4'b1111, 1'b0};
        vecs[16] = '{4'd14, 4'b1111, 1'b0};
        vecs[17] = '{4'd15, 4'b1111, 1'b0};

        // reset state
        #2;
        chk("rst_flags", flags, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cond_done", cond_done, 1'b0);
        chk("rst_cond_taken", cond_taken, 1'b0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            chk("rst_rd", rd_data, 16'h0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        // back-to-back accepts to the same register with wb_en high
        wb_en = 1'b1;
        rd_addr = 3'd1;
        in_valid = 1'b1;
        in_bus = 20'h01111;
        in_dest = 3'd1;
        in_flag_we = 1'b0;
        tick();
        chk("b2b_ready1", in_ready, 1'b1);
        in_bus = 20'h02222;
        tick();
        chk("b2b_ready2", in_ready, 1'b1);
`ifdef ALU_WB_BYPASS_EN
        chk("b2b_rd_mid", rd_data, 16'h2222);
`else
        chk("b2b_rd_mid", rd_data, 16'h1111);
`endif
        in_valid = 1'b0;
        tick();
        chk("b2b_rd_final", rd_data, 16'h2222);
        chk("b2b_flags", flags, 4'h0);

        // Z result to r3 with flag update
        push(20'h0BEEF, 3'd3, 1'b0);
        tick();
        rd_addr = 3'd3;
        #1;
        chk("r3_pre", rd_data, 16'hBEEF);
        push(20'h40000, 3'd3, 1'b1);
        tick();
        chk("z_flags", flags, 4'b0100);
        chk("z_r3", rd_data, 16'h0);
        cond_req("z_eq", 4'd1, 1'b1);
        cond_req("z_ne", 4'd2, 1'b0);

        // pending entry held while wb_en is low
        wb_en = 1'b0;
        rd_addr = 3'd5;
        push(20'h38000, 3'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_flags", flags, 4'b0100);
`ifdef ALU_WB_BYPASS_EN
            chk("hold_cond_ready", cond_ready, 1'b1);
            chk("hold_rd", rd_data, 16'h8000);
`else
            chk("hold_cond_ready", cond_ready, 1'b0);
            chk("hold_rd", rd_data, 16'h0);
`endif
            tick();
        end
`ifdef ALU_WB_BYPASS_EN
        cond_req("hold_mi_bypass", 4'd3, 1'b1);
        cond_req("hold_ge_bypass", 4'd10, 1'b1);
`endif
        wb_en = 1'b1;
        #1;
        chk("release_ready", in_ready, 1'b1);
        tick();
        chk("release_flags", flags, 4'b0011);
        chk("release_rd", rd_data, 16'h8000);
        chk("release_cond_ready", cond_ready, 1'b1);

        // flag_we=0 entry leaves flags alone; MI sees the old S
        set_flags(4'b0000);
        wb_en = 1'b0;
        rd_addr = 3'd6;
        push(20'h1FFFF, 3'd6, 1'b0);
        chk("nofwe_cond_ready", cond_ready, 1'b1);
        cond_req("nofwe_mi", 4'd3, 1'b0);
        wb_en = 1'b1;
        tick();
        chk("nofwe_flags", flags, 4'b0000);
        chk("nofwe_rd", rd_data, 16'hFFFF);

        // decode table
        for (int i = 0; i < 18; i++) begin
            set_flags(vecs[i].f);
            cond_req($sformatf("vec%0d_code%0d", i, vecs[i].code), vecs[i].code, vecs[i].exp);
        end

        // back-to-back condition requests, then held result
        set_flags(4'b0000);
        cond_valid = 1'b1;
        cond_code = 4'd0;
        tick();
        chk("bb_done1", cond_done, 1'b1);
        chk("bb_taken1", cond_taken, 1'b1);
        cond_code = 4'd13;
        tick();
        cond_valid = 1'b0;
        chk("bb_done2", cond_done, 1'b1);
        chk("bb_taken2", cond_taken, 1'b0);
        tick();
        chk("bb_done3", cond_done, 1'b0);
        chk("bb_taken_hold", cond_taken, 1'b0);
        cond_req("bb_al", 4'd0, 1'b1);
        tick();
        chk("al_taken_hold", cond_taken, 1'b1);

        // asynchronous reset mid-cycle with a pending entry
        wb_en = 1'b0;
        push(20'hFAAAA, 3'd2, 1'b1);
        chk("prerst_in_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_flags", flags, 4'h0);
        chk("mrst_taken", cond_taken, 1'b0);
        chk("mrst_done", cond_done, 1'b0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #0.1;
            chk("mrst_rd", rd_data, 16'h0);
        end
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        chk("mrst_in_ready", in_ready, 1'b1);
        wb_en = 1'b1;
        rd_addr = 3'd2;
        tick();
        tick();
        chk("mrst_no_commit_rd", rd_data, 16'h0);
        chk("mrst_no_commit_flags", flags, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
